// File: rtl/flag_branch_unit.sv
// flag_branch_unit: EX-stage flag register, BRFL branch resolution, divide-by-zero trap and registered MEM output.
module flag_branch_unit #(
  parameter int WIDTH = 32,
  parameter int NFLAGS = 5,
  parameter bit DIV_TRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        ALUControl,
  input  logic [WIDTH-1:0]  ALUResult,
  input  logic [NFLAGS-1:0] RFlags,
  input  logic [NFLAGS-1:0] BranchMask,
  input  logic [WIDTH-1:0]  BranchTarget,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  OutResult,
  output logic [NFLAGS-1:0] FlagReg,
  output logic              BranchTaken,
  output logic [WIDTH-1:0]  BranchPC,
  output logic              FlushReq,
  output logic              Trap,
  input  logic              TrapAck,
  output logic [31:0]       RetireCount
);
  localparam logic [4:0] OP_ADD = 5'b00110, OP_SUB = 5'b00111, OP_MULT = 5'b01000,
                         OP_DIV = 5'b01001, OP_CMP = 5'b01110, OP_BRFL = 5'b10010,
                         OP_NOP = 5'b10101;
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_nxt;
  logic accept, bubble, flag_wr, trap_hit, take;
  assign InReady = state == RUN && (!OutValid || OutReady);
  assign accept = InValid && InReady;
  // NOP and every code above it are bubbles
  assign bubble = ALUControl >= OP_NOP;
  assign flag_wr = ALUControl inside {OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_CMP};
  assign trap_hit = accept && DIV_TRAP_EN && ALUControl == OP_DIV && RFlags[0];
  assign take = accept && ALUControl == OP_BRFL && |(FlagReg & BranchMask);
  assign Trap = state == TRAP;
  always_comb begin
    state_nxt = state;
    state_nxt = state == RUN ? (trap_hit ? TRAP : RUN) : (TrapAck ? RUN : TRAP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      OutValid <= 1'b0;
      OutResult <= '0;
      FlagReg <= '0;
      BranchTaken <= 1'b0;
      BranchPC <= '0;
      FlushReq <= 1'b0;
      RetireCount <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !bubble && !trap_hit) begin
        OutValid <= 1'b1;
        OutResult <= ALUResult;
      end else if (OutReady) OutValid <= 1'b0;
      if (accept && flag_wr) FlagReg <= RFlags;
      BranchTaken <= take;
      FlushReq <= take;
      if (take) BranchPC <= BranchTarget;
      if (OutValid && OutReady) RetireCount <= RetireCount + 32'd1;
    end
  end
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed checks of flags, branches, handshake, trap and retire counter.
module tb_flag_branch_unit;
  localparam logic [4:0] ADD = 5'b00110, SUB = 5'b00111, DIV = 5'b01001, CMP = 5'b01110,
                         BRFL = 5'b10010, NOP = 5'b10101, UND = 5'b11111;
  logic clk = 0, rst = 1, InValid = 0, OutReady = 1, TrapAck = 0;
  logic [4:0] ALUControl = '0, RFlags = '0, BranchMask = '0;
  logic [31:0] ALUResult = '0, BranchTarget = '0;
  logic InReady, OutValid, BranchTaken, FlushReq, Trap;
  logic [31:0] OutResult, BranchPC, RetireCount;
  logic [4:0] FlagReg;
  logic InReady1, OutValid1, BranchTaken1, FlushReq1, Trap1;
  logic [31:0] OutResult1, BranchPC1, RetireCount1;
  logic [4:0] FlagReg1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  flag_branch_unit dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .RFlags(RFlags), .BranchMask(BranchMask), .BranchTarget(BranchTarget),
    .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult), .FlagReg(FlagReg),
    .BranchTaken(BranchTaken), .BranchPC(BranchPC), .FlushReq(FlushReq), .Trap(Trap),
    .TrapAck(TrapAck), .RetireCount(RetireCount)
  );
  flag_branch_unit #(.DIV_TRAP_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady1), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .RFlags(RFlags), .BranchMask(BranchMask), .BranchTarget(BranchTarget),
    .OutValid(OutValid1), .OutReady(OutReady), .OutResult(OutResult1), .FlagReg(FlagReg1),
    .BranchTaken(BranchTaken1), .BranchPC(BranchPC1), .FlushReq(FlushReq1), .Trap(Trap1),
    .TrapAck(TrapAck), .RetireCount(RetireCount1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [4:0] op, input logic [31:0] res, input logic [4:0] fl);
    InValid = 1;
    ALUControl = op;
    ALUResult = res;
    RFlags = fl;
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_outvalid", OutValid, 0);
    chk("rst_flagreg", FlagReg, 0);
    chk("rst_retire", RetireCount, 0);
    chk("rst_trap", Trap, 0);
    chk("rst_branchpc", BranchPC, 0);
    chk("rst_inready", InReady, 1);
    TrapAck = 1;
    tick();
    TrapAck = 0;
    chk("ack_in_run_trap", Trap, 0);
    chk("ack_in_run_ready", InReady, 1);
    issue(ADD, 32'h11, 5'b10000);
    tick();
    chk("add_flagreg", FlagReg, 5'b10000);
    chk("add_outvalid", OutValid, 1);
    chk("add_outresult", OutResult, 32'h11);
    issue(BRFL, 32'h22, 5'b00000);
    BranchMask = 5'b10000;
    BranchTarget = 32'h100;
    tick();
    InValid = 0;
    chk("brfl_taken", BranchTaken, 1);
    chk("brfl_flush", FlushReq, 1);
    chk("brfl_pc", BranchPC, 32'h100);
    chk("brfl_outresult", OutResult, 32'h22);
    chk("brfl_flag_kept", FlagReg, 5'b10000);
    tick();
    chk("brfl_taken_pulse_end", BranchTaken, 0);
    chk("brfl_flush_pulse_end", FlushReq, 0);
    chk("brfl_retire", RetireCount, 2);
    issue(CMP, 32'h33, 5'b00100);
    tick();
    chk("cmp_flagreg", FlagReg, 5'b00100);
    chk("cmp_no_trap", Trap, 0);
    issue(BRFL, 32'h34, 5'b00000);
    BranchMask = 5'b00010;
    BranchTarget = 32'h200;
    tick();
    InValid = 0;
    chk("brfl_nt_taken", BranchTaken, 0);
    chk("brfl_nt_flush", FlushReq, 0);
    chk("brfl_nt_pc", BranchPC, 32'h100);
    tick();
    chk("brfl_nt_taken2", BranchTaken, 0);
    chk("brfl_nt_retire", RetireCount, 4);
    OutReady = 0;
    issue(ADD, 32'h44, 5'b00000);
    tick();
    chk("stall_outvalid", OutValid, 1);
    chk("stall_outresult", OutResult, 32'h44);
    issue(SUB, 32'h55, 5'b00010);
    #1;
    chk("stall_inready", InReady, 0);
    tick();
    chk("stall_hold", OutResult, 32'h44);
    OutReady = 1;
    #1;
    chk("drain_inready", InReady, 1);
    tick();
    InValid = 0;
    chk("b2b_outresult", OutResult, 32'h55);
    chk("b2b_flagreg", FlagReg, 5'b00010);
    tick();
    chk("b2b_retire", RetireCount, 6);
    chk("b2b_outvalid", OutValid, 0);
    issue(DIV, 32'h66, 5'b00001);
    tick();
    InValid = 0;
    chk("div_trap", Trap, 1);
    chk("div_outvalid", OutValid, 0);
    chk("div_inready", InReady, 0);
    chk("div_flagreg", FlagReg, 5'b00001);
    chk("div_noen_trap", Trap1, 0);
    chk("div_noen_flag0", FlagReg1[0], 1);
    chk("div_noen_outvalid", OutValid1, 1);
    tick();
    chk("trap_held", Trap, 1);
    TrapAck = 1;
    tick();
    TrapAck = 0;
    chk("ack_trap", Trap, 0);
    chk("ack_inready", InReady, 1);
    issue(NOP, 32'h70, 5'b11111);
    tick();
    chk("nop_outvalid", OutValid, 0);
    chk("nop_flagreg", FlagReg, 5'b00001);
    issue(UND, 32'h71, 5'b11111);
    tick();
    InValid = 0;
    chk("und_outvalid", OutValid, 0);
    chk("und_flagreg", FlagReg, 5'b00001);
    tick();
    chk("bubble_retire", RetireCount, 6);
    OutReady = 0;
    issue(ADD, 32'h77, 5'b00000);
    tick();
    issue(DIV, 32'h88, 5'b00001);
    OutReady = 1;
    tick();
    InValid = 0;
    OutReady = 0;
    chk("trap_drain_retire", RetireCount, 7);
    chk("trap_squash_outvalid", OutValid, 0);
    chk("trap_after_drain", Trap, 1);
    chk("noen_div_result", OutResult1, 32'h88);
    tick();
    chk("trap_mid_outvalid1", OutValid1, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_trap_clear", Trap, 0);
    chk("rst_trap_inready", InReady, 1);
    chk("rst_trap_flagreg", FlagReg, 0);
    chk("rst_trap_retire", RetireCount, 0);
    chk("rst_hs_outvalid1", OutValid1, 0);
    chk("rst_hs_outresult1", OutResult1, 0);
    chk("rst_hs_branchpc", BranchPC, 0);
    OutReady = 1;
    force dut.RetireCount = 32'hFFFFFFFF;
    #1;
    release dut.RetireCount;
    #1;
    chk("preload_retire", RetireCount, 32'hFFFFFFFF);
    issue(ADD, 32'h99, 5'b00000);
    tick();
    InValid = 0;
    tick();
    chk("wrap_retire", RetireCount, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
